// File: rtl/axil_imem_rsp.sv
module axil_imem_rsp #(
  parameter int unsigned                ADDR_WIDTH  = 32,
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter int unsigned                DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned                RD_LATENCY  = 1,
  parameter string                      INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o
);

  localparam int unsigned MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_ERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MEM_AW-1:0]     idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [ADDR_WIDTH-1:0] off;
  logic                  ar_err;
  logic [MEM_AW-1:0]     ar_idx;
  logic [MEM_AW-1:0]     rd_idx;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    off    = araddr_i - BASE_ADDR;
    ar_err = (off[1:0] != 2'b00) || ((off >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));
    ar_idx = off[MEM_AW+1:2];
  end

  always_comb begin
    rd_idx  = (state_q == S_IDLE) ? ar_idx : idx_q;
    rd_err  = (state_q == S_IDLE) ? ar_err : err_q;
    rd_data = rd_err ? '0 : mem[rd_idx];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (arvalid_i && arready_q) begin
          idx_d     = ar_idx;
          err_d     = ar_err;
          arready_d = 1'b0;
          if (RD_LATENCY == 1) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = ar_err ? RESP_ERR : RESP_OK;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        arready_d = 1'b0;
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_data;
          rresp_d  = err_q ? RESP_ERR : RESP_OK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        arready_d = 1'b0;
        if (rready_i) begin
          state_d   = S_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axil_imem_rsp.sv
// Scoreboard bench for axil_imem_rsp: three instances with read latencies of
// 1, 3 and 4 are exercised one at a time.
module tb_axil_imem_rsp;

  localparam int          NI    = 3;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] word(input int i);
    if (i == 0) return 32'h0000_0413;
    if (i == 1) return 32'h00A0_0093;
    return 32'h1000_0000 + i;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        arvalid [NI];
  logic        arready [NI];
  logic [31:0] araddr  [NI];
  logic        rvalid  [NI];
  logic        rready  [NI];
  logic [31:0] rdata   [NI];
  logic [1:0]  rresp   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axil_imem_rsp #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .RD_LATENCY (lat_of(g)),
      .INIT_FILE  ("")
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .arvalid_i(arvalid[g]),
      .arready_o(arready[g]),
      .araddr_i (araddr[g]),
      .rvalid_o (rvalid[g]),
      .rready_i (rready[g]),
      .rdata_o  (rdata[g]),
      .rresp_o  (rresp[g])
    );
  end

  typedef struct {
    int          g;
    logic [31:0] d;
    logic [1:0]  r;
    int          t;
  } exp_t;

  exp_t        sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_beat = 0;
  logic        pending [NI];
  logic        in_beat [NI];
  logic [31:0] held_d  [NI];
  logic [1:0]  held_r  [NI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every R beat against the scoreboard head and checks
  // latency, R stability while stalled, and arready low while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < NI; g++) begin
        if (pending[g] && !rvalid[g])
          check($sformatf("arready_low_wait[%0d]", g), 32'(arready[g]), 32'd0);
        if (rvalid[g]) begin
          check($sformatf("arready_low_resp[%0d]", g), 32'(arready[g]), 32'd0);
          if (!in_beat[g]) begin
            if (sb.size() == 0 || sb[0].g != g) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_beat[%0d]: got rvalid=1 expected no beat", g);
            end else begin
              check($sformatf("latency[%0d]", g), 32'(cyc - sb[0].t), 32'(lat_of(g)));
            end
            in_beat[g] = 1'b1;
            pending[g] = 1'b0;
            held_d[g]  = rdata[g];
            held_r[g]  = rresp[g];
          end else begin
            check($sformatf("rdata_stable[%0d]", g), rdata[g], held_d[g]);
            check($sformatf("rresp_stable[%0d]", g), 32'(rresp[g]), 32'(held_r[g]));
          end
          if (rready[g]) begin
            if (sb.size() != 0 && sb[0].g == g) begin
              check($sformatf("rdata[%0d]", g), rdata[g], sb[0].d);
              check($sformatf("rresp[%0d]", g), 32'(rresp[g]), 32'(sb[0].r));
              void'(sb.pop_front());
            end
            in_beat[g] = 1'b0;
            last_beat  = cyc;
          end
        end else if (in_beat[g]) begin
          n_chk++;
          n_fail++;
          $display("FAIL rvalid_dropped[%0d]: got rvalid=0 expected 1", g);
          in_beat[g] = 1'b0;
        end
      end
    end
  end

  // Issue one AR. The expected beat is queued at the handshake, and t
  // returns the handshake cycle.
  task automatic do_ar(input int g, input logic [31:0] addr, input logic [31:0] ed,
                       input logic [1:0] er, output int t);
    bit ok = 1'b0;
    araddr[g]  = addr;
    arvalid[g] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (arready[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL ar_timeout[%0d]: got arready=0 expected 1 within 50 cycles", g);
      arvalid[g] = 1'b0;
      t = -1;
      return;
    end
    @(posedge clk);
    #1;
    arvalid[g] = 1'b0;
    t = cyc - 1;
    sb.push_back('{g: g, d: ed, r: er, t: t});
    pending[g] = 1'b1;
  endtask

  task automatic wait_idle(input int g);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rvalid[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout[%0d]: got %0d queued expected 0", g, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tb2;
    int ts [4];
    bit ok;
    for (int g = 0; g < NI; g++) begin
      arvalid[g] = 1'b0;
      araddr[g]  = '0;
      rready[g]  = 1'b1;
      pending[g] = 1'b0;
      in_beat[g] = 1'b0;
      held_d[g]  = '0;
      held_r[g]  = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      g_dut[0].u_dut.mem[i] = word(i);
      g_dut[1].u_dut.mem[i] = word(i);
      g_dut[2].u_dut.mem[i] = word(i);
    end

    // Reset values, then arready rises in the first cycle after release.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 32'(arready[0]), 32'd0);
    check("rst_rvalid",  32'(rvalid[0]),  32'd0);
    check("rst_rdata",   rdata[0],        32'd0);
    check("rst_rresp",   32'(rresp[0]),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arready_after_release", 32'(arready[0]), 32'd1);
    @(posedge clk);
    #1;

    // Latency 1: read word 0.
    do_ar(0, BASE, 32'h0000_0413, 2'b00, t);
    wait_idle(0);

    // Latency 3: read word 1.
    do_ar(1, BASE + 32'd4, 32'h00A0_0093, 2'b00, t);
    wait_idle(1);

    // Error cases, plus the last valid word.
    do_ar(0, BASE + 32'd2,  32'd0, 2'b10, t);
    do_ar(0, 32'h7FFF_FFFC, 32'd0, 2'b10, t);
    do_ar(0, BASE + 32'(4 * DEPTH), 32'd0, 2'b10, t);
    do_ar(0, BASE + 32'(4 * DEPTH - 4), 32'h1000_000F, 2'b00, t);
    wait_idle(0);

    // Stall R for 5 cycles while a second AR waits.
    rready[1] = 1'b0;
    do_ar(1, BASE + 32'd8, 32'h1000_0002, 2'b00, t);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (rvalid[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall_rvalid_seen", 32'(ok), 32'd1);
    araddr[1]  = BASE + 32'd12;
    arvalid[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stall_rvalid_held", 32'(rvalid[1]), 32'd1);
    rready[1] = 1'b1;
    do_ar(1, BASE + 32'd12, 32'h1000_0003, 2'b00, tb2);
    check("ar_after_beat", 32'(tb2 > last_beat), 32'd1);
    wait_idle(1);

    // Reset during WAIT with latency 4.
    do_ar(2, BASE + 32'd16, 32'h1000_0004, 2'b00, t);
    @(posedge clk);
    #1;
    sb.delete();
    pending[2] = 1'b0;
    in_beat[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid",  32'(rvalid[2]),  32'd0);
    check("midrst_arready", 32'(arready[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_arready_after", 32'(arready[2]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst_no_beat", 32'(rvalid[2]), 32'd0);
    end
    @(posedge clk);
    #1;
    do_ar(2, BASE + 32'd20, 32'h1000_0005, 2'b00, t);
    wait_idle(2);

    // Back-to-back with latency 1: one beat every 2 cycles.
    for (int k = 0; k < 4; k++)
      do_ar(0, BASE + 32'(4 * (k + 2)), word(k + 2), 2'b00, ts[k]);
    for (int k = 1; k < 4; k++)
      check($sformatf("b2b_spacing[%0d]", k), 32'(ts[k] - ts[k-1]), 32'd2);
    wait_idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
